// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - asynchronous 16-bit SRAM responder with read latency, bus turnaround and access counters
module sram_responder #(
  parameter int          ADDR_W      = 18,
  parameter int          READ_LAT    = 2,
  parameter logic [15:0] INVALID_PAT = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAM_addr,
  input  logic        SRAM_WE_N,
  inout  wire  [15:0] SRAM_data,
  output logic        rd_valid,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [2:0] LAT   = 3'(READ_LAT);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] addr_m;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        stab_cnt;
  logic [2:0]        stab_nxt;
  logic              we_n_q;
  logic              oe_q;
  logic              clr;
  logic              valid_nxt;
  logic [15:0]       dout;

  assign addr_m    = SRAM_addr[ADDR_W-1:0];
  assign clr       = !SRAM_WE_N || (addr_m != addr_q);
  assign valid_nxt = (stab_nxt == LAT);

  always_comb begin
    stab_nxt = stab_cnt;
    if (clr)
      stab_nxt = 3'd0;
    else if (stab_cnt >= LAT)
      stab_nxt = LAT;
    else
      stab_nxt = stab_cnt + 3'd1;
  end

  // Array has no reset; a write is suppressed on reset cycles only.
  always_ff @(posedge clk) begin
    if (rst && !SRAM_WE_N)
      mem[addr_m] <= SRAM_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stab_cnt <= 3'd0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      dout     <= INVALID_PAT;
      rd_valid <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      stab_cnt <= stab_nxt;
      addr_q   <= addr_m;
      we_n_q   <= SRAM_WE_N;
      oe_q     <= SRAM_WE_N;
      rd_valid <= valid_nxt;
      // Reloading while stable keeps dout coherent with the array.
      if (clr)
        dout <= INVALID_PAT;
      else if (valid_nxt)
        dout <= mem[addr_m];
      if (valid_nxt && !rd_valid && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
      if (!SRAM_WE_N && we_n_q && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end

  // oe_q delays drive by one cycle after WE_N rises; release on WE_N low is immediate.
  assign SRAM_data = (oe_q && SRAM_WE_N) ? dout : 16'hzzzz;

endmodule
